// File: rtl/fifo_pkg.sv
// Shared constants and helpers for stream_fifo.
// Optional checking is enabled with FIFO_OVERFLOW_CHECK_EN (see stream_fifo.sv).
package fifo_pkg;
    localparam int RAM_RD_LATENCY = 2;
    localparam int PREFETCH_DEPTH = 3;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/stream_fifo_if.sv
// Write side, show-ahead read side and status of stream_fifo.
interface stream_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] i_data;
    logic             i_wrreq;
    logic             o_full;
    logic             o_almost_full;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_rdreq;
    logic             o_empty;
    logic             o_almost_empty;
    logic [CW-1:0]    o_usedw;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_data, i_wrreq, i_rdreq,
        input  o_full, o_almost_full, o_data, o_valid, o_empty,
               o_almost_empty, o_usedw, o_overflow, o_underflow
    );

    modport slave (
        input  i_data, i_wrreq, i_rdreq,
        output o_full, o_almost_full, o_data, o_valid, o_empty,
               o_almost_empty, o_usedw, o_overflow, o_underflow
    );
endinterface

// File: rtl/stream_fifo_sdp_ram.sv
// Simple-dual-port RAM with registered address stage and output register
// (read latency 2); no read-during-write behaviour is relied upon.
module sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_q <= mem[raddr];
        rdata_q <= rd_q;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/stream_fifo.sv
// Show-ahead FIFO: block RAM plus a 3-entry prefetch buffer that hides RAM latency.
// Define FIFO_OVERFLOW_CHECK_EN to build sticky overflow/underflow flags.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int DEPTH              = 64,
    parameter int ALMOST_FULL_VALUE  = 1,
    parameter int ALMOST_EMPTY_VALUE = 1
) (
    input logic          clk,
    input logic          rst,
    stream_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_VALUE);
    localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_VALUE);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] usedw_q, usedw_d, ram_cnt_q, ram_cnt_d;
    logic [RAM_RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [1:0] pf_cnt_q, pf_cnt_d;
    logic [PREFETCH_DEPTH-1:0][WIDTH-1:0] pf_q, pf_d;
    logic valid_q, valid_d, full_q, full_d;
    logic afull_q, afull_d, aempty_q, aempty_d;
    logic wr_acc, rd_acc, rd_issue, push;
    logic [1:0] inflight, push_idx;
    logic [2:0] occ;
    logic [WIDTH-1:0] ram_rdata;

    sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr_q),
        .wdata (bus.i_data),
        .re    (rd_issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_acc   = bus.i_wrreq && !full_q;
        rd_acc   = bus.i_rdreq && valid_q;
        push     = rd_vld_q[RAM_RD_LATENCY-1];
        inflight = 2'($countones(rd_vld_q));
        // A pop this cycle frees a slot, so the engine keeps issuing at full rate.
        occ      = 3'(pf_cnt_q) + 3'(inflight) - 3'(rd_acc);
        rd_issue = (ram_cnt_q != '0) && (occ < 3'(PREFETCH_DEPTH));

        wr_ptr_d  = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + AW'(rd_issue);
        ram_cnt_d = ram_cnt_q + CW'(wr_acc) - CW'(rd_issue);
        usedw_d   = usedw_q + CW'(wr_acc) - CW'(rd_acc);
        rd_vld_d  = {rd_vld_q[RAM_RD_LATENCY-2:0], rd_issue};

        pf_d = pf_q;
        if (rd_acc) begin
            for (int i = 0; i < PREFETCH_DEPTH - 1; i++) pf_d[i] = pf_q[i+1];
        end
        push_idx = pf_cnt_q - 2'(rd_acc);
        if (push) begin
            for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                if (push_idx == 2'(i)) pf_d[i] = ram_rdata;
            end
        end
        pf_cnt_d = pf_cnt_q - 2'(rd_acc) + 2'(push);

        valid_d  = pf_cnt_d != 2'd0;
        full_d   = usedw_d == FULL_CNT;
        afull_d  = usedw_d >= AF_CNT;
        aempty_d = usedw_d < AE_CNT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            ram_cnt_q <= '0;
            rd_vld_q  <= '0;
            pf_cnt_q  <= '0;
            pf_q      <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usedw_q   <= usedw_d;
            ram_cnt_q <= ram_cnt_d;
            rd_vld_q  <= rd_vld_d;
            pf_cnt_q  <= pf_cnt_d;
            pf_q      <= pf_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    assign bus.o_data         = pf_q[0];
    assign bus.o_valid        = valid_q;
    assign bus.o_empty        = !valid_q;
    assign bus.o_full         = full_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_usedw        = usedw_q;

`ifdef FIFO_OVERFLOW_CHECK_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q || (bus.i_wrreq && full_q);
        udf_d = udf_q || (bus.i_rdreq && !valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = udf_q;
`else
    assign bus.o_overflow  = 1'b0;
    assign bus.o_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo with a queue scoreboard and a negedge monitor.
module tb_stream_fifo;
    import fifo_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int AFV   = 60;
    localparam int AEV   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stream_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH),
        .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard and reference occupancy model
    logic [WIDTH-1:0] sb[$];
    int m_cnt = 0;
    int n_reads = 0;
    bit armed = 0;
    bit m_ovf = 0, m_udf = 0;
    bit hold = 0;
    logic [WIDTH-1:0] hold_data;

    always @(negedge clk) begin
        bit wa, ra;
        if (armed) begin
            check("usedw", bus.o_usedw, m_cnt);
            check("full", bus.o_full, m_cnt == DEPTH);
            check("almost_full", bus.o_almost_full, m_cnt >= AFV);
            check("almost_empty", bus.o_almost_empty, m_cnt < AEV);
            check("empty_vs_valid", bus.o_empty, !bus.o_valid);
`ifdef FIFO_OVERFLOW_CHECK_EN
            check("overflow", bus.o_overflow, m_ovf);
            check("underflow", bus.o_underflow, m_udf);
`else
            check("overflow_tied", bus.o_overflow, 1'b0);
            check("underflow_tied", bus.o_underflow, 1'b0);
`endif
            if (hold) begin
                check("hold_valid", bus.o_valid, 1'b1);
                check("hold_data", bus.o_data, hold_data);
            end
            if (sb.size() == 0) check("spurious_valid", bus.o_valid, 1'b0);
        end
        hold = 0;
        if (rst) begin
            sb.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_udf = 0;
            armed = 1;
        end else if (armed) begin
            ra = bus.i_rdreq && bus.o_valid;
            wa = bus.i_wrreq && (m_cnt != DEPTH);
            if (bus.i_wrreq && m_cnt == DEPTH) m_ovf = 1;
            if (bus.i_rdreq && !bus.o_valid) m_udf = 1;
            if (ra) begin
                n_reads++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL read_no_data: got 0x%0h expected no valid word at %0t", bus.o_data, $time);
                end else begin
                    check("data", bus.o_data, sb.pop_front());
                end
            end
            if (wa) sb.push_back(bus.i_data);
            m_cnt += int'(wa) - int'(ra);
            hold = bus.o_valid && !bus.i_rdreq;
            hold_data = bus.o_data;
        end
    end

    task automatic cyc(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
        bus.i_wrreq = wr;
        bus.i_data  = d;
        bus.i_rdreq = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, '0, 0);
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, bus.o_valid, 1'b0);
        check({tag, "_empty"}, bus.o_empty, 1'b1);
        check({tag, "_full"}, bus.o_full, 1'b0);
        check({tag, "_afull"}, bus.o_almost_full, 1'b0);
        check({tag, "_aempty"}, bus.o_almost_empty, 1'b1);
        check({tag, "_usedw"}, bus.o_usedw, 0);
        check({tag, "_data"}, bus.o_data, 0);
        check({tag, "_ovf"}, bus.o_overflow, 1'b0);
        check({tag, "_udf"}, bus.o_underflow, 1'b0);
    endtask

    initial begin
        int r0;
        int wcnt;
        bus.i_wrreq = 1'b0;
        bus.i_data  = '0;
        bus.i_rdreq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("rst");

        // Single write: visible four cycles after the write cycle
        cyc(1, 32'hA5, 0);
        check("lat_valid_1", bus.o_valid, 1'b0);
        check("lat_usedw", bus.o_usedw, 1);
        check("lat_empty_1", bus.o_empty, 1'b1);
        cyc(0, '0, 0);
        check("lat_valid_2", bus.o_valid, 1'b0);
        cyc(0, '0, 0);
        check("lat_valid_3", bus.o_valid, 1'b0);
        cyc(0, '0, 0);
        check("lat_valid_4", bus.o_valid, 1'b1);
        check("lat_data", bus.o_data, 32'hA5);
        check("lat_empty_4", bus.o_empty, 1'b0);
        cyc(0, '0, 1);
        cyc(0, '0, 0);
        check("lat_drained", bus.o_usedw, 0);

        // Fill to capacity, then write+read while full, then drain in order
        do_reset();
        r0 = n_reads;
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h100 + i, 0);
        check("fill_full", bus.o_full, 1'b1);
        check("fill_usedw", bus.o_usedw, 64);
        check("fill_afull", bus.o_almost_full, 1'b1);
`ifdef FIFO_OVERFLOW_CHECK_EN
        cyc(1, 32'hDEAD, 0);
        check("ovf_set", bus.o_overflow, 1'b1);
        check("ovf_usedw", bus.o_usedw, 64);
`endif
        cyc(1, 32'hBEEF, 1);
        check("full_rw_usedw", bus.o_usedw, 63);
        check("full_rw_full", bus.o_full, 1'b0);
        for (int i = 0; i < 70; i++) cyc(0, '0, 1);
        check("drain_usedw", bus.o_usedw, 0);
        check("drain_empty", bus.o_empty, 1'b1);
        check("drain_count", n_reads - r0, 64);
`ifdef FIFO_OVERFLOW_CHECK_EN
        check("ovf_sticky", bus.o_overflow, 1'b1);
        check("udf_set", bus.o_underflow, 1'b1);
`endif

        // Streaming: one write and one read per cycle
        do_reset();
        r0 = n_reads;
        for (int i = 0; i < 500; i++) begin
            cyc(1, WIDTH'(i), 1);
            if (i >= 3) begin
                check("stream_valid", bus.o_valid, 1'b1);
                check("stream_usedw", bus.o_usedw, 4);
            end
        end
        for (int i = 0; i < 10; i++) cyc(0, '0, 1);
        check("stream_count", n_reads - r0, 500);
        check("stream_drained", bus.o_usedw, 0);

        // Random traffic crossing pointer wrap
        do_reset();
        wcnt = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), WIDTH'(wcnt), 1'($urandom_range(0, 1)));
            wcnt++;
        end
        for (int i = 0; i < 80; i++) cyc(0, '0, 1);
        check("rand_drained", bus.o_usedw, 0);

        // Reset with words held and reads in flight
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 32'h200 + i, 0);
        rst = 1'b1;
        cyc(1, 32'h77, 1);
        rst = 1'b0;
        check_reset_vals("midrst");
        cyc(1, 32'h1, 0);
        for (int i = 0; i < 10 && !bus.o_valid; i++) cyc(0, '0, 0);
        check("post_rst_valid", bus.o_valid, 1'b1);
        check("post_rst_data", bus.o_data, 32'h1);
        cyc(0, '0, 1);
        repeat (3) cyc(0, '0, 0);
        check("final_usedw", bus.o_usedw, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
